// File: rtl/legv8_ctrl_pkg.sv
// legv8_ctrl_pkg: shared opcodes, ALU function codes, FSM states and instruction classes
package legv8_ctrl_pkg;
  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [9:0]  OP_ADDI = 10'b1001000100;
  localparam logic [9:0]  OP_SUBI = 10'b1101000100;
  localparam logic [7:0]  OP_CBZ  = 8'b10110100;
  localparam logic [5:0]  OP_B    = 6'b000101;
  localparam logic [4:0]  FS_AND  = 5'b00000;
  localparam logic [4:0]  FS_OR   = 5'b00100;
  localparam logic [4:0]  FS_ADD  = 5'b01000;
  localparam logic [4:0]  FS_SUB  = 5'b01001;
  localparam logic [4:0]  XZR     = 5'd31;
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_HALT} state_t;
  typedef enum logic [3:0] {
    I_ADD, I_SUB, I_AND, I_ORR, I_ADDI, I_SUBI,
    I_LDUR, I_STUR, I_CBZ, I_B, I_HALT, I_ILL
  } iclass_t;
endpackage

// File: rtl/legv8_control_unit_if.sv
// legv8_control_unit_if: instruction and data memory request/acknowledge handshakes
interface legv8_control_unit_if;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_data;
  logic        dmem_req;
  logic        dmem_we;
  logic        dmem_ack;
  modport master (output imem_req, imem_addr, dmem_req, dmem_we, input imem_ack, imem_data, dmem_ack);
  modport slave  (input imem_req, imem_addr, dmem_req, dmem_we, output imem_ack, imem_data, dmem_ack);
endinterface

// File: rtl/legv8_decoder.sv
// legv8_decoder: maps an instruction word to its class, register fields and extended immediate
module legv8_decoder
  import legv8_ctrl_pkg::*;
(
  input  logic [31:0] ir,
  output iclass_t     cls,
  output logic [4:0]  rn,
  output logic [4:0]  rm,
  output logic [4:0]  rd,
  output logic [63:0] imm
);
  assign rn = ir[9:5];
  assign rm = ir[20:16];
  assign rd = ir[4:0];
  // widest opcodes are matched first; imm is K for I/D types and the byte offset for branches
  always_comb begin
    cls = ir == '0 ? I_HALT :
          ir[31:21] == OP_ADD  ? I_ADD  :
          ir[31:21] == OP_SUB  ? I_SUB  :
          ir[31:21] == OP_AND  ? I_AND  :
          ir[31:21] == OP_ORR  ? I_ORR  :
          ir[31:21] == OP_LDUR ? I_LDUR :
          ir[31:21] == OP_STUR ? I_STUR :
          ir[31:22] == OP_ADDI ? I_ADDI :
          ir[31:22] == OP_SUBI ? I_SUBI :
          ir[31:24] == OP_CBZ  ? I_CBZ  :
          ir[31:26] == OP_B    ? I_B    : I_ILL;
    imm = (cls == I_ADDI || cls == I_SUBI) ? {52'b0, ir[21:10]} :
          (cls == I_LDUR || cls == I_STUR) ? {{55{ir[20]}}, ir[20:12]} :
          cls == I_CBZ ? {{43{ir[23]}}, ir[23:5], 2'b00} :
          {{36{ir[25]}}, ir[25:0], 2'b00};
  end
endmodule

// File: rtl/legv8_control_unit.sv
// legv8_control_unit: multi-cycle LEGv8 fetch/decode/execute sequencer driving the datapath control word
module legv8_control_unit
  import legv8_ctrl_pkg::*;
(
  input  logic                        clock,
  input  logic                        reset,
  legv8_control_unit_if.master        mem,
  input  logic [3:0]                  status,
  output logic [4:0]                  SA,
  output logic [4:0]                  SB,
  output logic [4:0]                  DA,
  output logic                        W,
  output logic [4:0]                  FS,
  output logic                        C_in,
  output logic                        B_SEL,
  output logic [63:0]                 K,
  output logic                        EN_ALU,
  output logic                        EN_B,
  output logic                        EN_RAM,
  output logic [63:0]                 pc,
  output logic                        halted,
  output logic                        illegal
);
  state_t      state, state_n;
  iclass_t     cls_d, cls_q;
  logic [31:0] ir;
  logic [4:0]  rn_d, rm_d, rd_d, rn_q, rm_q, rd_q;
  logic [63:0] imm_d, imm_q, pc_n, pc_4;
  logic        i_type, alu_op, is_sub, is_st, unused_flags;

  legv8_decoder u_dec (.ir(ir), .cls(cls_d), .rn(rn_d), .rm(rm_d), .rd(rd_d), .imm(imm_d));

  assign pc_4           = pc + 64'd4;
  assign i_type         = cls_q == I_ADDI || cls_q == I_SUBI;
  assign alu_op         = i_type || cls_q inside {I_ADD, I_SUB, I_AND, I_ORR};
  assign is_sub         = cls_q == I_SUB || cls_q == I_SUBI;
  assign is_st          = cls_q == I_STUR;
  assign halted         = state == S_HALT;
  assign mem.imem_addr  = pc;
  assign unused_flags   = ^status[3:1];

  // state, PC, instruction register and the fields latched during DECODE
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state <= S_IDLE;
      pc    <= '0;
      ir    <= '0;
      cls_q <= I_HALT;
      rn_q  <= XZR;
      rm_q  <= XZR;
      rd_q  <= XZR;
      imm_q <= '0;
    end else begin
      state <= state_n;
      pc    <= pc_n;
      if (state == S_FETCH && mem.imem_ack) ir <= mem.imem_data;
      if (state == S_DECODE) begin
        cls_q <= cls_d;
        rn_q  <= rn_d;
        rm_q  <= rm_d;
        rd_q  <= rd_d;
        imm_q <= imm_d;
      end
    end

  // next state, next PC and the Moore control word; only EN_RAM/W on the load ack follow ack
  always_comb begin
    state_n      = state;
    pc_n         = pc;
    SA           = XZR;
    SB           = XZR;
    DA           = XZR;
    W            = 1'b0;
    FS           = FS_AND;
    C_in         = 1'b0;
    B_SEL        = 1'b0;
    K            = '0;
    EN_ALU       = 1'b0;
    EN_B         = 1'b0;
    EN_RAM       = 1'b0;
    illegal      = 1'b0;
    mem.imem_req = 1'b0;
    mem.dmem_req = 1'b0;
    mem.dmem_we  = 1'b0;
    case (state)
      S_IDLE: state_n = S_FETCH;
      S_FETCH: begin
        mem.imem_req = 1'b1;
        state_n      = mem.imem_ack ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        illegal = cls_d == I_ILL;
        pc_n    = illegal ? pc_4 : pc;
        state_n = cls_d == I_HALT ? S_HALT : illegal ? S_FETCH : S_EXEC;
      end
      S_EXEC: begin
        if (alu_op) begin
          SA      = rn_q;
          SB      = i_type ? XZR : rm_q;
          DA      = rd_q;
          B_SEL   = i_type;
          K       = i_type ? imm_q : '0;
          FS      = cls_q == I_AND ? FS_AND : cls_q == I_ORR ? FS_OR : is_sub ? FS_SUB : FS_ADD;
          C_in    = is_sub;
          EN_ALU  = 1'b1;
          W       = 1'b1;
          pc_n    = pc_4;
          state_n = S_FETCH;
        end else if (cls_q == I_LDUR || is_st) begin
          SA      = rn_q;
          B_SEL   = 1'b1;
          K       = imm_q;
          FS      = FS_ADD;
          state_n = S_MEM;
        end else begin
          SB      = cls_q == I_CBZ ? rd_q : XZR;
          FS      = cls_q == I_CBZ ? FS_ADD : FS_AND;
          pc_n    = (cls_q == I_B || (cls_q == I_CBZ && status[0])) ? pc + imm_q : pc_4;
          state_n = S_FETCH;
        end
      end
      S_MEM: begin
        SA           = rn_q;
        B_SEL        = 1'b1;
        K            = imm_q;
        FS           = FS_ADD;
        mem.dmem_req = 1'b1;
        mem.dmem_we  = is_st;
        SB           = is_st ? rd_q : XZR;
        EN_B         = is_st;
        DA           = is_st ? XZR : rd_q;
        EN_RAM       = !is_st && mem.dmem_ack;
        W            = EN_RAM;
        pc_n         = mem.dmem_ack ? pc_4 : pc;
        state_n      = mem.dmem_ack ? S_FETCH : S_MEM;
      end
      default: ;
    endcase
  end
endmodule

// File: doc/legv8_control_unit.md
# legv8_control_unit

Multi-cycle control unit that fetches LEGv8 instructions, decodes them and drives the control word (SA, SB, DA, W, FS, C_in, B_SEL, K, EN_ALU, EN_B, EN_RAM) into the 64-bit LEGv8 datapath. It owns the program counter and sequences the instruction-memory and data-memory request/acknowledge handshakes. It is the initiator/sequencer end of the datapath's control interface.

## Interface
- No parameters; widths are fixed. Data is 64 bits and instructions are 32 bits.
- `clock` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: **asynchronous, active-low** (0 = reset).
- `imem_req` out 1: instruction fetch request; `imem_addr` out 64 = pc.
- `imem_ack` in 1: fetch data valid this cycle; `imem_data` in 32: instruction word.
- `dmem_req` out 1, `dmem_we` out 1: data-memory access and write strobe. `dmem_ack` in 1: access complete; load data is on the D bus this cycle.
- `status` in 4: ALU flags {V,C,N,Z}.
- `SA`, `SB`, `DA` out 5 each: register selects.
- `W` out 1: register-file write enable.
- `FS` out 5 and `C_in` out 1: ALU function and carry-in.
- `B_SEL` out 1: 1 = K drives the ALU B input.
- `K` out 64: immediate.
- `EN_ALU`, `EN_B`, `EN_RAM` out 1 each: D-bus tri-state enables. At most one is high in any cycle.
- `pc` out 64: current PC.
- `halted` out 1: the unit is in HALT.
- `illegal` out 1: one-cycle pulse on an undecodable opcode.

## Operation
- States are IDLE, FETCH, DECODE, EXEC, MEM and HALT.
- Reset: state IDLE, pc=0, IR=0. All outputs are 0 except SA=SB=DA=31 (XZR).
- IDLE goes to FETCH unconditionally. Exactly one cycle is spent in IDLE after reset deasserts.
- FETCH: `imem_req`=1 and `imem_addr`=pc, held stable until `imem_ack`. On ack, IR<=imem_data and the next state is DECODE.
- DECODE: one cycle. Fields and K are registered here.
  - All-zero IR goes to HALT.
  - An unknown opcode pulses `illegal`, sets pc+=4 and returns to FETCH.
- EXEC, by instruction:
  - ADD/SUB/AND/ORR: SA=Rn, SB=Rm, DA=Rd, B_SEL=0, EN_ALU=1, W=1. Then pc+=4 and go to FETCH.
  - ADDI/SUBI: the same, but B_SEL=1 and K=zero-extended imm12.
  - FS encoding: ADD=FS_ADD with C_in=0; SUB=FS_ADD with C_in=1 and B inverted (FS_SUB); AND=FS_AND; ORR=FS_OR.
  - LDUR/STUR: SA=Rn, B_SEL=1, K=sign-extended imm9, FS_ADD. Go to MEM.
  - CBZ: SA=31, SB=Rt, B_SEL=0, FS_ADD.
    - If status[0] (Z) is set: pc += sext(imm19)<<2.
    - Otherwise: pc+=4.
  - B: pc += sext(imm26)<<2. The ALU is idle.
- MEM: `dmem_req`=1 and the address control word is held until `dmem_ack`.
  - Load: DA=Rt. On the ack cycle EN_RAM=1 and W=1.
  - Store: SB=Rt, EN_B=1, `dmem_we`=1 throughout.
  - On ack: pc+=4 and go to FETCH.
- HALT is absorbing, with `halted`=1. Only reset exits it.
- W is only ever high in EXEC (R/I type) or on the MEM load ack cycle.

## Timing
- Latencies, with zero-wait memory (ack in the first request cycle):
  - R/I type and branches: 3 cycles (FETCH, DECODE, EXEC).
  - Loads and stores: 4 cycles.
- Each wait cycle adds one cycle. Request outputs are Moore (state-decoded) and never depend combinationally on ack.
- An ack arriving while no request is outstanding is ignored.
- PC arithmetic is modulo 2^64. Negative offsets wrap.
- The CBZ decision samples `status` at the end of the EXEC cycle.
- Reset mid-operation, in any state, aborts immediately: requests drop in the same cycle (asynchronous) and no W is issued.
- EN_ALU, EN_B and EN_RAM are mutually exclusive every cycle; verification asserts this.

## Structure
- Package `legv8_ctrl_pkg` holds:
  - opcode constants for ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000, LDUR 11111000010, STUR 11111000000 (11-bit); ADDI 1001000100, SUBI 1101000100 (10-bit); CBZ 10110100 (8-bit); B 000101 (6-bit);
  - FS_AND, FS_OR, FS_ADD and FS_SUB;
  - the state encoding;
  - the XZR index, 31.
- Sub-module `legv8_decoder` is combinational. It maps IR to an instruction class, register fields and the extended immediate.
- The top level holds the FSM, PC and IR.

## Test plan
- Reset then ADD X1,X2,X3 (0x8B030041) with zero-wait ack: imem_req high at cycle 1; EXEC has SA=2, SB=3, DA=1, EN_ALU=W=1; pc=4.
- ADDI X5,X5,#0xFFF with imem_ack delayed 3 cycles: imem_addr stays stable; K=0x0000000000000FFF and B_SEL=1; 6 cycles total.
- LDUR X4,[X6,#-8]: K=0xFFFFFFFFFFFFFFF8 and dmem_req high until ack; W and EN_RAM high only on the ack cycle with DA=4. STUR: dmem_we=EN_B=1 and W never asserted.
- CBZ X7,#-2 at pc=0x100:
  - status Z=1 gives pc=0xF8;
  - Z=0 gives pc=0x104.
  - B with imm26 of all ones at pc=0 gives pc=0xFFFFFFFFFFFFFFFC.
- Unknown opcode 0xFFFFFFFF pulses illegal for 1 cycle and sets pc+=4. Word 0x00000000 gives halted=1 and no further imem_req.
- Reset asserted while in MEM with dmem_req high: dmem_req drops asynchronously, no W, and the unit resumes at pc=0 from IDLE.
